// File: rtl/filter_output_packer.sv
// filter_output_packer
// Sits behind the adaptive integrator/differentiator filter. Drops the filter's
// settling samples after reset and after every mode change, cuts the accepted
// samples into fixed-length frames, and buffers them in a FIFO. The FIFO feeds an
// AXI-Stream master whose outputs are all registered.
module filter_output_packer #(
  parameter int DATA_WIDTH     = 14,
  parameter int FIFO_DEPTH     = 16,
  parameter int FRAME_LEN      = 64,
  parameter int SETTLE_SAMPLES = 10
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  ctrl,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_tuser,
  output logic                  overflow
);

  localparam int IDX_W   = $clog2(FRAME_LEN);
  localparam int CNT_W   = $clog2(SETTLE_SAMPLES + 1);
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int ENTRY_W = DATA_WIDTH + 2;

  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(FRAME_LEN - 1);
  localparam logic [CNT_W-1:0] SETTLE_DONE = CNT_W'(SETTLE_SAMPLES);
  localparam logic [PTR_W:0]   FULL_COUNT  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic {
    ST_SETTLE = 1'b0,
    ST_RUN    = 1'b1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic                 ctrl_q;
  logic                 mode_change;
  logic [CNT_W-1:0]     settle_cnt_q;
  logic [CNT_W-1:0]     settle_cnt_d;
  logic [CNT_W-1:0]     settle_base;
  logic [CNT_W-1:0]     settle_inc;
  logic [IDX_W-1:0]     frame_idx_q;

  logic                  stage_valid_q;
  logic [DATA_WIDTH-1:0] stage_data_q;
  logic                  stage_mode_q;
  logic [IDX_W-1:0]      stage_idx_q;

  logic                  load;
  logic                  push;
  logic                  push_last;
  logic [ENTRY_W-1:0]    push_entry;

  logic [ENTRY_W-1:0]    fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      head_ptr;
  logic [PTR_W:0]        fifo_count;
  logic [PTR_W:0]        count_after_pop;
  logic                  pop;
  logic                  push_ok;

  assign mode_change = (ctrl != ctrl_q);

  // Mode history register; tracks ctrl even through reset so reset itself is no mode change
  always_ff @(posedge clk) begin
    ctrl_q <= ctrl;
  end

  // FSM state and settle counter registers
  always_ff @(posedge clk) begin
    if (srst) begin
      state_q      <= ST_SETTLE;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  // Next state: a mode change restarts settling, and a sample in that same cycle is settle sample 1
  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    settle_base  = mode_change ? '0 : settle_cnt_q;
    settle_inc   = settle_base + CNT_W'(1);
    if ((mode_change || (state_q == ST_SETTLE)) && s_tvalid) begin
      if (settle_inc == SETTLE_DONE) begin
        state_d      = ST_RUN;
        settle_cnt_d = '0;
      end else begin
        state_d      = ST_SETTLE;
        settle_cnt_d = settle_inc;
      end
    end else if (mode_change) begin
      state_d      = ST_SETTLE;
      settle_cnt_d = '0;
    end
  end

  // FSM outputs: stage load, and stage push when a frame closes or a new sample displaces it
  always_comb begin
    load       = (state_q == ST_RUN) && !mode_change && s_tvalid;
    push_last  = (stage_idx_q == LAST_IDX) || mode_change;
    push       = stage_valid_q && (load || push_last);
    push_entry = {stage_mode_q, push_last, stage_data_q};
  end

  // Frame position counter; it ignores FIFO drops, so frames stay aligned to the input count
  always_ff @(posedge clk) begin
    if (srst || mode_change) begin
      frame_idx_q <= '0;
    end else if (load) begin
      frame_idx_q <= (frame_idx_q == LAST_IDX) ? '0 : frame_idx_q + IDX_W'(1);
    end
  end

  // One-entry stage holding the newest sample until its push trigger arrives
  always_ff @(posedge clk) begin
    if (srst) begin
      stage_valid_q <= 1'b0;
      stage_data_q  <= '0;
      stage_mode_q  <= 1'b0;
      stage_idx_q   <= '0;
    end else if (load) begin
      stage_valid_q <= 1'b1;
      stage_data_q  <= s_tdata;
      stage_mode_q  <= ctrl;
      stage_idx_q   <= frame_idx_q;
    end else if (push) begin
      stage_valid_q <= 1'b0;
    end
  end

  assign pop             = m_tvalid && m_tready;
  assign push_ok         = push && ((fifo_count != FULL_COUNT) || pop);
  assign count_after_pop = fifo_count - (PTR_W + 1)'(pop);
  assign head_ptr        = pop ? rd_ptr + PTR_W'(1) : rd_ptr;

  // FIFO storage; a push into a full FIFO is accepted when the head leaves in the same cycle
  always_ff @(posedge clk) begin
    if (push_ok) begin
      fifo_mem[wr_ptr] <= push_entry;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag
  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      fifo_count <= fifo_count + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop);
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
    end
  end

  // Registered output view of the FIFO head; held while the sink stalls
  always_ff @(posedge clk) begin
    if (srst) begin
      m_tvalid <= 1'b0;
      m_tdata  <= '0;
      m_tlast  <= 1'b0;
      m_tuser  <= 1'b0;
    end else begin
      m_tvalid <= (count_after_pop != '0);
      if (count_after_pop != '0) begin
        {m_tuser, m_tlast, m_tdata} <= fifo_mem[head_ptr];
      end
    end
  end

endmodule

// File: tb/tb_filter_output_packer.sv
// tb_filter_output_packer
// Directed stimulus with a scoreboard queue; the monitor pops and compares every
// accepted output beat independently of the stimulus process.
module tb_filter_output_packer;

  localparam int DW = 14;
  localparam int FD = 4;
  localparam int FL = 4;
  localparam int SS = 3;

  logic          clk = 1'b0;
  logic          srst;
  logic          ctrl;
  logic [DW-1:0] s_tdata;
  logic          s_tvalid;
  logic [DW-1:0] m_tdata;
  logic          m_tvalid;
  logic          m_tready;
  logic          m_tlast;
  logic          m_tuser;
  logic          overflow;

  logic [DW+1:0] sb_q [$];
  logic [DW+1:0] exp_beat;
  int            total_checks = 0;
  int            bad_checks   = 0;
  int            cyc          = 0;
  int            c0;
  int            lat;

  filter_output_packer #(
    .DATA_WIDTH    (DW),
    .FIFO_DEPTH    (FD),
    .FRAME_LEN     (FL),
    .SETTLE_SAMPLES(SS)
  ) dut (
    .clk     (clk),
    .srst    (srst),
    .ctrl    (ctrl),
    .s_tdata (s_tdata),
    .s_tvalid(s_tvalid),
    .m_tdata (m_tdata),
    .m_tvalid(m_tvalid),
    .m_tready(m_tready),
    .m_tlast (m_tlast),
    .m_tuser (m_tuser),
    .overflow(overflow)
  );

  // Free-running clock
  always #5 clk = ~clk;

  // Cycle counter used for latency measurement
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total_checks++;
    if (actual !== expected) begin
      bad_checks++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  // One input sample; keep/last/user describe the beat it should produce, if any
  task automatic applyStimulus(input logic c, input logic [DW-1:0] d, input logic keep,
                               input logic last, input logic user);
    @(posedge clk);
    #1;
    ctrl     = c;
    s_tvalid = 1'b1;
    s_tdata  = d;
    if (keep) sb_q.push_back({user, last, d});
  endtask

  task automatic applyIdle(input logic c, input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      ctrl     = c;
      s_tvalid = 1'b0;
    end
  endtask

  task automatic waitDrain(input string name);
    for (int i = 0; i < 40; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    checkOutput(name, 32'(sb_q.size()), 32'd0);
  endtask

  task automatic doReset();
    @(posedge clk);
    #1;
    srst     = 1'b1;
    s_tvalid = 1'b0;
    sb_q.delete();
    @(posedge clk);
    #1;
    srst = 1'b0;
  endtask

  // Monitor: every accepted beat must match the head of the scoreboard
  always @(negedge clk) begin
    if (!srst && m_tvalid && m_tready) begin
      if (sb_q.size() == 0) begin
        total_checks++;
        bad_checks++;
        $display("[TB] FAIL unexpected_beat: got data=0x%0h last=%0b user=%0b expected no beat",
                 m_tdata, m_tlast, m_tuser);
      end else begin
        exp_beat = sb_q.pop_front();
        checkOutput("beat{user,last,data}", 32'({m_tuser, m_tlast, m_tdata}), 32'(exp_beat));
      end
    end
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed test sequence
  initial begin
    srst     = 1'b1;
    ctrl     = 1'b0;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    m_tready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("reset_tdata", 32'(m_tdata), 32'd0);
    checkOutput("reset_tlast", 32'(m_tlast), 32'd0);
    checkOutput("reset_tuser", 32'(m_tuser), 32'd0);
    checkOutput("reset_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    srst = 1'b0;

    $display("[TB] settle discard");
    for (int i = 1; i <= 7; i++) applyStimulus(1'b0, DW'(i), i >= 4, i == 7, 1'b0);
    applyIdle(1'b0, 2);
    waitDrain("settle_drain");
    applyIdle(1'b0, 6);

    $display("[TB] frame tail flush");
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, DW'(14'h00A + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, DW'(14'h100 + i), 1'b1, i == 3, 1'b0);
    c0 = cyc;
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    lat = 999;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_tvalid && m_tdata == DW'(14'h103)) begin
        lat = cyc - c0;
        break;
      end
    end
    checkOutput("tail_latency", 32'(lat), 32'd3);
    waitDrain("tail_drain");
    applyIdle(1'b0, 4);

    $display("[TB] mode change");
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, DW'(i + 1), 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 14'h010, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 14'h011, 1'b1, 1'b1, 1'b0);
    applyIdle(1'b1, 1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, DW'(14'h020 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, DW'(14'h030 + i), 1'b1, i == 3, 1'b1);
    applyStimulus(1'b1, 14'h034, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, DW'(14'h040 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, DW'(14'h043 + i), 1'b1, i == 3, 1'b0);
    applyIdle(1'b0, 2);
    waitDrain("mode_drain");
    applyIdle(1'b0, 4);

    $display("[TB] backpressure and overflow");
    m_tready = 1'b0;
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, DW'(i + 1), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, DW'(14'h050 + i), i < 4, i == 3, 1'b0);
    applyIdle(1'b0, 3);
    @(negedge clk);
    checkOutput("ovf_set", 32'(overflow), 32'd1);
    checkOutput("ovf_tvalid_held", 32'(m_tvalid), 32'd1);
    checkOutput("ovf_tdata_held", 32'(m_tdata), 32'h050);
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    waitDrain("ovf_drain");
    applyIdle(1'b0, 4);
    checkOutput("ovf_sticky", 32'(overflow), 32'd1);

    $display("[TB] reset mid-frame");
    @(posedge clk);
    #1;
    m_tready = 1'b0;
    applyStimulus(1'b0, 14'h070, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 14'h071, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 14'h072, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    srst     = 1'b1;
    s_tvalid = 1'b0;
    sb_q.delete();
    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_tvalid", 32'(m_tvalid), 32'd0);
    checkOutput("rst_tdata", 32'(m_tdata), 32'd0);
    checkOutput("rst_tlast", 32'(m_tlast), 32'd0);
    checkOutput("rst_tuser", 32'(m_tuser), 32'd0);
    checkOutput("rst_overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    srst     = 1'b0;
    m_tready = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, DW'(14'h080 + i), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, DW'(14'h083 + i), 1'b1, i == 3, 1'b0);
    applyIdle(1'b0, 2);
    waitDrain("rst_drain");
    applyIdle(1'b0, 4);

    $display("[TB] full with simultaneous pop");
    m_tready = 1'b0;
    doReset();
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, DW'(i + 1), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, DW'(14'h060 + i), 1'b1, i == 3, 1'b0);
    @(posedge clk);
    #1;
    m_tready = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 14'h065;
    sb_q.push_back({1'b0, 1'b0, 14'h065});
    applyStimulus(1'b0, 14'h066, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 14'h067, 1'b1, 1'b1, 1'b0);
    applyIdle(1'b0, 2);
    waitDrain("full_pop_drain");
    applyIdle(1'b0, 4);
    checkOutput("full_pop_no_ovf", 32'(overflow), 32'd0);

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule

// File: doc/filter_output_packer.md
Name: filter_output_packer

Overview:
Stage directly downstream of the adaptive integrator/differentiator filter. Consumes its valid-only Q8.6 sample stream and the ctrl mode line. Discards filter settling samples after reset and after every mode change. Groups accepted samples into fixed-length frames and buffers them in a FIFO, presenting an AXI-Stream master with backpressure, tlast and mode tag.

Parameters:
DATA_WIDTH, 14, sample width (signed Q8.6, bit pattern passed through unchanged)
FIFO_DEPTH, 16, FIFO entries; power of two, >= 4
FRAME_LEN, 64, samples per frame; >= 2
SETTLE_SAMPLES, 10, samples discarded after reset or a ctrl change (filter delay-line length); >= 1

Ports:
clk  in  1  clock, all logic on rising edge
srst  in  1  synchronous active-high reset
ctrl  in  1  filter mode (1 integrator, 0 differentiator), same signal that drives the filter
s_tdata  in  DATA_WIDTH  filter output sample
s_tvalid  in  1  sample strobe, no backpressure, may be high every cycle
m_tdata  out  DATA_WIDTH  buffered sample
m_tvalid  out  1  FIFO non-empty
m_tready  in  1  downstream accept
m_tlast  out  1  last sample of frame
m_tuser  out  1  ctrl value at which the sample was captured
overflow  out  1  sticky: at least one sample dropped on full FIFO; cleared only by srst

Behaviour:
- Reset: srst high at an edge -> m_tvalid=0, m_tdata=0, m_tlast=0, m_tuser=0, overflow=0; FIFO empty; stage empty; frame index 0; settle count 0; state SETTLE; ctrl_q<=ctrl. Reset mid-operation discards all buffered data.
- Mode-change event: ctrl != ctrl_q in a cycle; ctrl_q<=ctrl every cycle.
- FSM SETTLE: each s_tvalid sample is discarded and increments settle count. The sample that brings the count to SETTLE_SAMPLES -> RUN and is also discarded. The first SETTLE_SAMPLES samples are dropped.
- FSM RUN: each s_tvalid sample is loaded into a one-entry stage register with {data, mode=ctrl, idx=frame index}. Frame index then advances, wrapping FRAME_LEN-1 -> 0.
- Stage push triggers (stage valid required): a new sample is loaded, OR a mode-change event, OR the stage idx == FRAME_LEN-1 (pushed the cycle after capture even with no further input).
- Pushed tlast = (idx == FRAME_LEN-1) OR push caused by a mode-change event. Push and load can occur in the same cycle.
- Mode-change event in any state:
  - stage flushed with tlast=1 and tuser = old mode; partial frames always close.
  - frame index <= 0, settle count <= 0, state <= SETTLE.
  - A sample arriving in that same cycle counts as settle sample 1 and is discarded.
  - A change during SETTLE restarts the count.
- FIFO: entries {tuser, tlast, data}.
  - Push accepted if not full, or if full with a pop in the same cycle.
  - Otherwise the entry is dropped and overflow<=1. Frame index is unaffected by drops, so frame boundaries stay aligned to input count.
  - Pop on m_tvalid & m_tready.
  - m_tvalid rises the cycle after the first push into an empty FIFO.
  - Outputs are registered and held stable while m_tvalid & !m_tready.
- Latency: a RUN sample at edge N sits in stage from N+1. A frame-final sample appears on m_tvalid at N+3 with an empty FIFO and m_tready=1.
- Throughput: one sample per cycle sustained when m_tready stays high.
- Data is not modified. Width and sign are untouched.

Test Plan:
- Settle: FRAME_LEN=4, SETTLE_SAMPLES=3, ctrl=0, send 0x0001..0x0007 back-to-back, m_tready=1 -> output 0x0004,0x0005,0x0006,0x0007 (tuser=0), tlast only on 0x0007; nothing further.
- Frame tail flush: same config, send 3 settle samples + 0x0100..0x0103, then s_tvalid=0 -> 0x0103 emitted with tlast=1 exactly 3 cycles after its input, no extra input needed.
- Mode change mid-frame: in RUN send 0x0010,0x0011, toggle ctrl 0->1 one cycle later -> 0x0011 emitted with tlast=1, tuser=0; the next 3 samples are dropped; the following sample is emitted with tuser=1 and starts a new frame (its tlast after 4 samples).
- Backpressure/overflow: FIFO_DEPTH=4, m_tready=0, stream 10 RUN samples -> 4 entries held, overflow=1. Release m_tready -> first 4 samples out in order, overflow stays 1.
- Full with simultaneous pop: FIFO full, m_tready=1 on the cycle of a push -> push accepted, overflow stays 0, order preserved.
- Reset mid-frame: assert srst with 3 entries queued -> next cycle m_tvalid=0, all outputs 0, overflow=0; after release the first SETTLE_SAMPLES samples are discarded again.
